// File: rtl/pu_ctrl_pkg.sv
// pu_ctrl_pkg: FSM state encoding, beat width and PU address widths shared by pu_ctrl and the PU.
package pu_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, WLOAD, COMPUTE, DRAIN, FIN} state_t;
    localparam int BEAT_W   = 512;
    localparam int W_AW     = 7;
    localparam int R_AW     = 7;
    localparam int CACHE_AW = 5;
    localparam int BIAS_AW  = 3;
    localparam int PSUM_W   = 7;
    localparam int NOUT_W   = 6;
endpackage

// File: rtl/pu_ctrl_if.sv
// pu_ctrl_if: weight-load and activation streams into pu_ctrl.
//   in_wld_valid/in_wld_data/out_wld_ready : weight beats for wmem
//   in_act_valid/in_act_data/out_act_ready : activation beats for the MACs
//   master = stream source, slave = pu_ctrl
interface pu_ctrl_if import pu_ctrl_pkg::*; #(parameter int BW = BEAT_W);
    logic          in_wld_valid;
    logic [BW-1:0] in_wld_data;
    logic          out_wld_ready;
    logic          in_act_valid;
    logic [BW-1:0] in_act_data;
    logic          out_act_ready;
    modport master (output in_wld_valid, in_wld_data, in_act_valid, in_act_data,
                    input  out_wld_ready, out_act_ready);
    modport slave  (input  in_wld_valid, in_wld_data, in_act_valid, in_act_data,
                    output out_wld_ready, out_act_ready);
endinterface

// File: rtl/pu_wb_pipe.sv
// pu_wb_pipe: LAT-deep (valid, index) delay line timing rmem writebacks.
//   in_valid/in_idx   : output finished this cycle and its index
//   out_valid/out_idx : same, LAT cycles later
//   busy              : any stage holds a pending writeback
module pu_wb_pipe #(
    parameter int LAT = 2,
    parameter int IW  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          busy
);
    logic [LAT-1:0] v;
    logic [IW-1:0]  idx [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < LAT; i++) idx[i] <= '0;
        end else begin
            v[0]   <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                v[i]   <= v[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end
    assign out_valid = v[LAT-1];
    assign out_idx   = idx[LAT-1];
    assign busy      = |v;
endmodule

// File: rtl/pu_ctrl.sv
// pu_ctrl: job sequencer for one PU -- loads weights, streams activations into the MACs,
// schedules rmem writebacks and signals job completion.
//   clk, rst_n        : clock, async active-low reset
//   bus               : weight/activation streams (slave side)
//   in_start + config : job request and its parameters, latched on acceptance
//   out_mac_en..      : per-beat MAC/cache/bias/relu strobes (combinational on a handshake)
//   out_w_*           : wmem write/read ports, out_r_*: rmem writeback
//   out_busy          : not IDLE, out_job_done: one-cycle completion pulse
module pu_ctrl import pu_ctrl_pkg::*; #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_MAC4    = 16,
    parameter int WADDR_WIDTH = W_AW,
    parameter int RADDR_WIDTH = R_AW,
    parameter int MAC_LAT     = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    pu_ctrl_if.slave                           bus,
    input  logic                               in_start,
    input  logic [PSUM_W-1:0]                  in_num_psum,
    input  logic [NOUT_W-1:0]                  in_num_out,
    input  logic [WADDR_WIDTH-1:0]             in_w_base,
    input  logic [RADDR_WIDTH-1:0]             in_r_base,
    input  logic [BIAS_AW-1:0]                 in_bias_addr,
    input  logic                               in_bias_en,
    input  logic                               in_relu_en,
    output logic                               out_mac_en,
    output logic [NUM_MAC4*4*DATA_WIDTH-1:0]   out_data,
    output logic                               out_add_bias,
    output logic                               out_relu,
    output logic                               out_done,
    output logic                               out_cache_clear,
    output logic                               out_cache_wr_en,
    output logic [CACHE_AW-1:0]                out_cache_rd_addr,
    output logic [CACHE_AW-1:0]                out_cache_wr_addr,
    output logic                               out_w_wr_en,
    output logic [WADDR_WIDTH-1:0]             out_w_wr_addr,
    output logic [NUM_MAC4*4*DATA_WIDTH-1:0]   out_w_wr_data,
    output logic [WADDR_WIDTH-1:0]             out_w_rd_addr,
    output logic [BIAS_AW-1:0]                 out_bias_addr,
    output logic                               out_r_wr_en,
    output logic [RADDR_WIDTH-1:0]             out_r_wr_addr,
    output logic                               out_busy,
    output logic                               out_job_done
);
    state_t                 state;
    logic [PSUM_W-1:0]      num_psum, p;
    logic [NOUT_W-1:0]      num_out;
    logic [CACHE_AW-1:0]    o;
    logic [WADDR_WIDTH-1:0] w_base;
    logic [RADDR_WIDTH-1:0] r_base;
    logic [BIAS_AW-1:0]     bias_addr;
    logic                   bias_en, relu_en, cache_clear;
    logic                   wbeat, abeat, last_p, last_o, done;
    logic                   wb_valid, wb_busy;
    logic [CACHE_AW-1:0]    wb_idx;

    assign wbeat  = state == WLOAD && bus.in_wld_valid;
    assign abeat  = state == COMPUTE && bus.in_act_valid;
    assign last_p = p == num_psum - 1'b1;
    assign last_o = {1'b0, o} == num_out - 1'b1;
    assign done   = abeat && last_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            p           <= '0;
            o           <= '0;
            num_psum    <= '0;
            num_out     <= '0;
            w_base      <= '0;
            r_base      <= '0;
            bias_addr   <= '0;
            bias_en     <= 1'b0;
            relu_en     <= 1'b0;
            cache_clear <= 1'b1;
        end else begin
            cache_clear <= 1'b1;
            case (state)
                IDLE: if (in_start && in_num_psum != '0 && in_num_out != '0) begin
                    state       <= WLOAD;
                    p           <= '0;
                    o           <= '0;
                    num_psum    <= in_num_psum;
                    num_out     <= in_num_out;
                    w_base      <= in_w_base;
                    r_base      <= in_r_base;
                    bias_addr   <= in_bias_addr;
                    bias_en     <= in_bias_en;
                    relu_en     <= in_relu_en;
                    cache_clear <= 1'b0;
                end
                WLOAD: if (wbeat) begin
                    p <= last_p ? '0 : p + 1'b1;
                    if (last_p) state <= COMPUTE;
                end
                COMPUTE: if (abeat) begin
                    p <= last_p ? '0 : p + 1'b1;
                    if (last_p) begin
                        o <= last_o ? '0 : o + 1'b1;
                        if (last_o) state <= DRAIN;
                    end
                end
                DRAIN:   if (!wb_busy) state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    pu_wb_pipe #(.LAT(MAC_LAT), .IW(CACHE_AW)) u_wb (
        .clk(clk), .rst_n(rst_n), .in_valid(done), .in_idx(o),
        .out_valid(wb_valid), .out_idx(wb_idx), .busy(wb_busy)
    );

    assign bus.out_wld_ready = state == WLOAD;
    assign bus.out_act_ready = state == COMPUTE;
    assign out_w_wr_en       = wbeat;
    assign out_w_wr_addr     = wbeat ? w_base + WADDR_WIDTH'(p) : '0;
    assign out_w_wr_data     = wbeat ? bus.in_wld_data : '0;
    assign out_mac_en        = abeat;
    assign out_data          = abeat ? bus.in_act_data : '0;
    assign out_w_rd_addr     = abeat ? w_base + WADDR_WIDTH'(p) : '0;
    assign out_cache_wr_en   = abeat;
    assign out_cache_rd_addr = abeat ? o : '0;
    assign out_cache_wr_addr = abeat ? o : '0;
    assign out_done          = done;
    assign out_add_bias      = done && bias_en;
    assign out_relu          = done && relu_en;
    assign out_bias_addr     = done ? bias_addr : '0;
    assign out_cache_clear   = cache_clear;
    assign out_r_wr_en       = wb_valid;
    assign out_r_wr_addr     = wb_valid ? r_base + RADDR_WIDTH'(wb_idx) : '0;
    assign out_busy          = state != IDLE;
    assign out_job_done      = state == FIN;
endmodule

// File: tb/tb_pu_ctrl.sv
// tb_pu_ctrl: scoreboard bench for pu_ctrl.
module tb_pu_ctrl;
    localparam int LAT = 2;

    typedef struct { logic [6:0] addr; logic [511:0] data; } wexp_t;
    typedef struct {
        logic [6:0]   w_rd;
        logic [4:0]   cache;
        logic         done;
        logic         bias;
        logic         relu;
        logic [2:0]   baddr;
        logic [511:0] data;
        logic [6:0]   raddr;
    } aexp_t;
    typedef struct { logic [6:0] addr; int cyc; } rexp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_start;
    logic [6:0]   in_num_psum;
    logic [5:0]   in_num_out;
    logic [6:0]   in_w_base, in_r_base;
    logic [2:0]   in_bias_addr;
    logic         in_bias_en, in_relu_en;
    logic         out_mac_en, out_add_bias, out_relu, out_done, out_cache_clear, out_cache_wr_en;
    logic [511:0] out_data, out_w_wr_data;
    logic [4:0]   out_cache_rd_addr, out_cache_wr_addr;
    logic         out_w_wr_en, out_r_wr_en, out_busy, out_job_done;
    logic [6:0]   out_w_wr_addr, out_w_rd_addr, out_r_wr_addr;
    logic [2:0]   out_bias_addr;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    wexp_t wq[$];
    aexp_t aq[$];
    rexp_t rq[$];
    wexp_t we;
    aexp_t ae;
    rexp_t re;

    pu_ctrl_if bus_if ();

    pu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if.slave),
        .in_start(in_start), .in_num_psum(in_num_psum), .in_num_out(in_num_out),
        .in_w_base(in_w_base), .in_r_base(in_r_base), .in_bias_addr(in_bias_addr),
        .in_bias_en(in_bias_en), .in_relu_en(in_relu_en),
        .out_mac_en(out_mac_en), .out_data(out_data), .out_add_bias(out_add_bias),
        .out_relu(out_relu), .out_done(out_done), .out_cache_clear(out_cache_clear),
        .out_cache_wr_en(out_cache_wr_en), .out_cache_rd_addr(out_cache_rd_addr),
        .out_cache_wr_addr(out_cache_wr_addr), .out_w_wr_en(out_w_wr_en),
        .out_w_wr_addr(out_w_wr_addr), .out_w_wr_data(out_w_wr_data),
        .out_w_rd_addr(out_w_rd_addr), .out_bias_addr(out_bias_addr),
        .out_r_wr_en(out_r_wr_en), .out_r_wr_addr(out_r_wr_addr),
        .out_busy(out_busy), .out_job_done(out_job_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_n) begin
        if (out_w_wr_en) begin
            vectors++;
            if (wq.size() == 0) begin
                miscompares++;
                $display("FAIL w_wr unexpected beat addr=%0d", out_w_wr_addr);
            end else begin
                we = wq.pop_front();
                if (out_w_wr_addr !== we.addr || out_w_wr_data !== we.data) begin
                    miscompares++;
                    $display("FAIL w_wr addr=%0d data_ok=%b required addr=%0d", out_w_wr_addr,
                             out_w_wr_data === we.data, we.addr);
                end
            end
        end
        if (out_mac_en) begin
            vectors++;
            if (aq.size() == 0) begin
                miscompares++;
                $display("FAIL mac_beat unexpected w_rd_addr=%0d", out_w_rd_addr);
            end else begin
                ae = aq.pop_front();
                if ({out_w_rd_addr, out_cache_rd_addr, out_cache_wr_addr, out_cache_wr_en, out_done,
                     out_add_bias, out_relu, out_bias_addr} !==
                    {ae.w_rd, ae.cache, ae.cache, 1'b1, ae.done, ae.bias, ae.relu, ae.baddr} ||
                    out_data !== ae.data) begin
                    miscompares++;
                    $display("FAIL mac_beat w_rd=%0d crd=%0d cwr=%0d cwe=%b done=%b bias=%b relu=%b baddr=%0d data_ok=%b required w_rd=%0d cache=%0d done=%b bias=%b relu=%b baddr=%0d",
                             out_w_rd_addr, out_cache_rd_addr, out_cache_wr_addr, out_cache_wr_en,
                             out_done, out_add_bias, out_relu, out_bias_addr, out_data === ae.data,
                             ae.w_rd, ae.cache, ae.done, ae.bias, ae.relu, ae.baddr);
                end
                if (ae.done) rq.push_back('{ae.raddr, cyc + LAT});
            end
        end
        if (out_r_wr_en) begin
            vectors++;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL r_wr unexpected addr=%0d cycle=%0d", out_r_wr_addr, cyc);
            end else begin
                re = rq.pop_front();
                if (out_r_wr_addr !== re.addr || cyc !== re.cyc) begin
                    miscompares++;
                    $display("FAIL r_wr addr=%0d cycle=%0d required addr=%0d cycle=%0d",
                             out_r_wr_addr, cyc, re.addr, re.cyc);
                end
            end
        end
    end

    task automatic send_wld(input logic [511:0] d, input logic [6:0] a);
        bit got;
        @(posedge clk); #1;
        bus_if.in_wld_valid = 1'b1;
        bus_if.in_wld_data  = d;
        wq.push_back('{a, d});
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.out_wld_ready) begin got = 1; break; end
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL wld_handshake ready=0 required=1"); end
    endtask

    task automatic send_act(input aexp_t e, input bit gap, input bit st);
        bit got;
        @(posedge clk); #1;
        bus_if.in_wld_valid = 1'b0;
        bus_if.in_act_valid = 1'b1;
        bus_if.in_act_data  = e.data;
        in_start = st;
        aq.push_back(e);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.out_act_ready) begin got = 1; break; end
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL act_handshake ready=0 required=1"); end
        if (gap) begin
            @(posedge clk); #1;
            bus_if.in_act_valid = 1'b0;
            in_start = 1'b0;
            @(negedge clk);
            vectors++;
            if ({out_mac_en, out_cache_wr_en, out_done, out_add_bias, out_relu} !== 5'b0) begin
                miscompares++;
                $display("FAIL stall_strobes mac/cwe/done/bias/relu=%b required 00000",
                         {out_mac_en, out_cache_wr_en, out_done, out_add_bias, out_relu});
            end
        end
    endtask

    task automatic run_job(input int psum, input int nout, input int wb, input int rb, input int ba,
                           input bit ben, input bit ren, input bit gap, input bit poke);
        aexp_t e;
        bit got;
        @(posedge clk); #1;
        in_start = 1'b1;
        in_num_psum = 7'(psum);
        in_num_out = 6'(nout);
        in_w_base = 7'(wb);
        in_r_base = 7'(rb);
        in_bias_addr = 3'(ba);
        in_bias_en = ben;
        in_relu_en = ren;
        @(posedge clk); #1;
        in_start = 1'b0;
        in_num_psum = 7'(psum + 3);
        in_num_out = 6'(nout + 1);
        in_w_base = ~in_w_base;
        in_r_base = ~in_r_base;
        in_bias_addr = ~in_bias_addr;
        in_bias_en = ~ben;
        in_relu_en = ~ren;
        @(negedge clk);
        vectors++;
        if ({out_busy, out_cache_clear, bus_if.out_wld_ready, bus_if.out_act_ready} !== 4'b1010) begin
            miscompares++;
            $display("FAIL wload_entry busy/clear/wld_rdy/act_rdy=%b required 1010",
                     {out_busy, out_cache_clear, bus_if.out_wld_ready, bus_if.out_act_ready});
        end
        for (int k = 0; k < psum; k++) begin
            send_wld({16{$urandom()}}, 7'(wb + k));
            if (k == 0) begin
                vectors++;
                if ({out_cache_clear, bus_if.out_act_ready} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL wload_second clear/act_rdy=%b required 10",
                             {out_cache_clear, bus_if.out_act_ready});
                end
            end
        end
        for (int o = 0; o < nout; o++) begin
            for (int p = 0; p < psum; p++) begin
                e.w_rd  = 7'(wb + p);
                e.cache = 5'(o);
                e.done  = p == psum - 1;
                e.bias  = e.done && ben;
                e.relu  = e.done && ren;
                e.baddr = e.done ? 3'(ba) : 3'd0;
                e.data  = {16{$urandom()}};
                e.raddr = 7'(rb + o);
                send_act(e, gap, poke && o == 0 && p == 0);
            end
        end
        @(posedge clk); #1;
        bus_if.in_act_valid = 1'b0;
        in_start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_busy, bus_if.out_act_ready, out_mac_en, out_job_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL drain busy/act_rdy/mac/job_done=%b required 1000",
                     {out_busy, bus_if.out_act_ready, out_mac_en, out_job_done});
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_job_done) begin got = 1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL job_done timeout seen=0 required=1"); end
        @(negedge clk);
        vectors++;
        if ({out_job_done, out_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL job_end job_done/busy=%b required 00", {out_job_done, out_busy});
        end
        vectors++;
        if (wq.size() + aq.size() + rq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expect w=%0d a=%0d r=%0d required 0 0 0", wq.size(), aq.size(), rq.size());
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_busy, out_cache_clear, out_job_done, out_mac_en, out_w_wr_en, out_r_wr_en,
             out_cache_wr_en, out_done, bus_if.out_wld_ready, bus_if.out_act_ready} !== 10'b0100000000) begin
            miscompares++;
            $display("FAIL reset_strobes got=%b required 0100000000",
                     {out_busy, out_cache_clear, out_job_done, out_mac_en, out_w_wr_en, out_r_wr_en,
                      out_cache_wr_en, out_done, bus_if.out_wld_ready, bus_if.out_act_ready});
        end
        vectors++;
        if ({out_w_wr_addr, out_w_rd_addr, out_r_wr_addr, out_cache_rd_addr, out_cache_wr_addr,
             out_bias_addr, out_add_bias, out_relu} !== '0 || out_data !== '0 || out_w_wr_data !== '0) begin
            miscompares++;
            $display("FAIL reset_addr_data w_wr=%0d w_rd=%0d r_wr=%0d required all 0",
                     out_w_wr_addr, out_w_rd_addr, out_r_wr_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_busy, out_cache_clear, out_job_done} !== 3'b010) begin
            miscompares++;
            $display("FAIL idle_after_reset busy/clear/job_done=%b required 010",
                     {out_busy, out_cache_clear, out_job_done});
        end
    endtask

    task automatic test_basic;
        run_job(2, 1, 0, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_job(1, 4, 20, 126, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        run_job(2, 2, 8, 30, 6, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            in_start = 1'b1;
            in_num_psum = c == 0 ? 7'd3 : 7'd0;
            in_num_out = c == 0 ? 6'd0 : 6'd2;
            @(posedge clk); #1;
            in_start = 1'b0;
            @(negedge clk);
            vectors++;
            if ({out_busy, bus_if.out_wld_ready, out_cache_clear} !== 3'b001) begin
                miscompares++;
                $display("FAIL zero_count_start busy/wld_rdy/clear=%b required 001",
                         {out_busy, bus_if.out_wld_ready, out_cache_clear});
            end
        end
        run_job(2, 2, 10, 20, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_drain;
        aexp_t e;
        @(posedge clk); #1;
        in_start = 1'b1;
        in_num_psum = 7'd1;
        in_num_out = 6'd1;
        in_w_base = 7'd3;
        in_r_base = 7'd9;
        in_bias_addr = 3'd2;
        in_bias_en = 1'b1;
        in_relu_en = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        send_wld({16{$urandom()}}, 7'd3);
        e.w_rd = 7'd3;
        e.cache = 5'd0;
        e.done = 1'b1;
        e.bias = 1'b1;
        e.relu = 1'b1;
        e.baddr = 3'd2;
        e.data = {16{$urandom()}};
        e.raddr = 7'd9;
        send_act(e, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus_if.in_act_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_busy, out_cache_clear, out_job_done, out_mac_en, out_w_wr_en, out_r_wr_en,
             out_cache_wr_en, out_done, bus_if.out_wld_ready, bus_if.out_act_ready} !== 10'b0100000000 ||
            out_r_wr_addr !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_in_drain strobes=%b r_wr_addr=%0d required 0100000000 0",
                     {out_busy, out_cache_clear, out_job_done, out_mac_en, out_w_wr_en, out_r_wr_en,
                      out_cache_wr_en, out_done, bus_if.out_wld_ready, bus_if.out_act_ready}, out_r_wr_addr);
        end
        rq.delete();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin @(posedge clk); #1; rst_n = 1'b1; end
            @(negedge clk);
            vectors++;
            if ({out_r_wr_en, out_job_done, out_busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL aborted_job r_wr/job_done/busy=%b required 000",
                         {out_r_wr_en, out_job_done, out_busy});
            end
        end
        vectors++;
        if (wq.size() + aq.size() + rq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_after_abort w=%0d a=%0d r=%0d required 0 0 0", wq.size(), aq.size(), rq.size());
        end
    endtask

    task automatic test_wrap;
        run_job(3, 1, 127, 50, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        in_start = 1'b0;
        in_num_psum = '0;
        in_num_out = '0;
        in_w_base = '0;
        in_r_base = '0;
        in_bias_addr = '0;
        in_bias_en = 1'b0;
        in_relu_en = 1'b0;
        bus_if.in_wld_valid = 1'b0;
        bus_if.in_wld_data = '0;
        bus_if.in_act_valid = 1'b0;
        bus_if.in_act_data = '0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_stall;
        test_ignore_start;
        test_reset_drain;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end
endmodule
